// File: rtl/tone_voice_bank.sv
`default_nettype none
// ============================================================================
// Module   : tone_voice_bank
// Purpose  : Four half-period square-wave voices mixed to a 3-bit level and
//            rendered as a 4-cycle-frame PWM bit for the speaker pin.
// Revision : 1.0
// ============================================================================
module tone_voice_bank #(
    parameter int PRESCALE = 1,
    parameter int PS_W     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] freq1,
    input  logic [7:0] freq2,
    input  logic [7:0] freq3,
    input  logic [7:0] freq4,
    output logic [3:0] voice,
    output logic [2:0] mix,
    output logic       pwm_out,
    output logic       tick
);

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q, ps_d;
    logic            tick_q, tick_d;
    logic [7:0]      freq_w [4];
    logic [2:0]      mix_q, mix_d;
    logic [1:0]      f_q, f_d;
    logic            pwm_q, pwm_d;

    assign freq_w[0] = freq1;
    assign freq_w[1] = freq2;
    assign freq_w[2] = freq3;
    assign freq_w[3] = freq4;

    // tick is registered so it is low throughout reset even when PRESCALE=1
    always_comb begin
        ps_d   = (ps_q == PS_LAST) ? '0 : ps_q + PS_W'(1);
        tick_d = (ps_d == PS_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps_q   <= '0;
            tick_q <= 1'b0;
        end else begin
            ps_q   <= ps_d;
            tick_q <= tick_d;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_voice
        logic [7:0] hp_q, hp_d;
        logic [7:0] cnt_q, cnt_d;
        logic       v_q, v_d;

        // hp==0 is IDLE; a boundary resamples freq so half-periods never truncate
        always_comb begin
            hp_d  = hp_q;
            cnt_d = cnt_q;
            v_d   = v_q;
            if (tick_q) begin
                if (hp_q == 8'd0) begin
                    v_d   = 1'b0;
                    cnt_d = 8'd0;
                    hp_d  = freq_w[gi];
                end else if (cnt_q == hp_q - 8'd1) begin
                    cnt_d = 8'd0;
                    hp_d  = freq_w[gi];
                    v_d   = (freq_w[gi] != 8'd0) ? ~v_q : 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                hp_q  <= 8'd0;
                cnt_q <= 8'd0;
                v_q   <= 1'b0;
            end else begin
                hp_q  <= hp_d;
                cnt_q <= cnt_d;
                v_q   <= v_d;
            end
        end

        assign voice[gi] = v_q;
    end

    always_comb begin
        mix_d = {2'b00, voice[0]} + {2'b00, voice[1]}
              + {2'b00, voice[2]} + {2'b00, voice[3]};
        f_d   = f_q + 2'd1;
        pwm_d = ({1'b0, f_q} < mix_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mix_q <= 3'd0;
            f_q   <= 2'd0;
            pwm_q <= 1'b0;
        end else begin
            mix_q <= mix_d;
            f_q   <= f_d;
            pwm_q <= pwm_d;
        end
    end

    assign mix     = mix_q;
    assign pwm_out = pwm_q;
    assign tick    = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_tone_voice_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_tone_voice_bank
// Purpose  : Checks two tone_voice_bank instances (PRESCALE 1 and 4) against
//            a tick/remaining-ticks reference model every clock.
// Revision : 1.0
// ============================================================================
module tb_tone_voice_bank;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] freq [4];
    logic [3:0] voice_o [2];
    logic [2:0] mix_o   [2];
    logic       pwm_o   [2];
    logic       tick_o  [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tone_voice_bank #(.PRESCALE(1), .PS_W(16)) u_dut1 (
        .clk(clk), .reset(reset),
        .freq1(freq[0]), .freq2(freq[1]), .freq3(freq[2]), .freq4(freq[3]),
        .voice(voice_o[0]), .mix(mix_o[0]), .pwm_out(pwm_o[0]), .tick(tick_o[0])
    );

    tone_voice_bank #(.PRESCALE(4), .PS_W(16)) u_dut4 (
        .clk(clk), .reset(reset),
        .freq1(freq[0]), .freq2(freq[1]), .freq3(freq[2]), .freq4(freq[3]),
        .voice(voice_o[1]), .mix(mix_o[1]), .pwm_out(pwm_o[1]), .tick(tick_o[1])
    );

    // Reference: per voice, a running flag, ticks left in the current
    // half-period and the output level; frame phase is edges-since-reset mod 4.
    int P [2] = '{1, 4};
    int k   [2];
    bit tk  [2];
    bit run [2][4];
    int rem [2][4];
    bit lvl [2][4];
    int mixm[2];
    bit pwmm[2];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                k[d] = 0; tk[d] = 0; mixm[d] = 0; pwmm[d] = 0;
                for (int v = 0; v < 4; v++) begin
                    run[d][v] = 0; rem[d][v] = 0; lvl[d][v] = 0;
                end
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                int pc;
                pc = 0;
                for (int v = 0; v < 4; v++) pc += int'(lvl[d][v]);
                pwmm[d] = ((k[d] % 4) < mixm[d]);
                mixm[d] = pc;
                if (tk[d]) begin
                    for (int v = 0; v < 4; v++) begin
                        if (!run[d][v]) begin
                            lvl[d][v] = 0;
                            if (freq[v] != 0) begin
                                run[d][v] = 1;
                                rem[d][v] = int'(freq[v]);
                            end
                        end else begin
                            rem[d][v]--;
                            if (rem[d][v] == 0) begin
                                if (freq[v] != 0) begin
                                    lvl[d][v] = ~lvl[d][v];
                                    rem[d][v] = int'(freq[v]);
                                end else begin
                                    run[d][v] = 0;
                                    lvl[d][v] = 0;
                                end
                            end
                        end
                    end
                end
                k[d]++;
                tk[d] = ((k[d] % P[d]) == P[d] - 1);
            end
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            int ev;
            ev = 0;
            for (int v = 0; v < 4; v++) ev |= int'(lvl[d][v]) << v;
            check($sformatf("voice[P%0d]", P[d]), int'(voice_o[d]), ev);
            check($sformatf("mix[P%0d]",   P[d]), int'(mix_o[d]),   mixm[d]);
            check($sformatf("pwm[P%0d]",   P[d]), int'(pwm_o[d]),   int'(pwmm[d]));
            check($sformatf("tick[P%0d]",  P[d]), int'(tick_o[d]),  int'(tk[d]));
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            compare_all();
        end
    endtask

    task automatic set_freq(input int f1, input int f2, input int f3, input int f4);
        freq[0] = 8'(f1); freq[1] = 8'(f2); freq[2] = 8'(f3); freq[3] = 8'(f4);
    endtask

    initial begin
        set_freq(5, 0, 0, 0);
        step(3);
        for (int d = 0; d < 2; d++) begin
            check("reset_voice", int'(voice_o[d]), 0);
            check("reset_pwm",   int'(pwm_o[d]),   0);
            check("reset_tick",  int'(tick_o[d]),  0);
        end
        reset = 1'b1;
        step(60);

        // freq2=3 on the slow instance, plus a mid-half-period retune on voice 1
        set_freq(10, 3, 0, 0);
        step(30);
        set_freq(2, 3, 0, 0);
        step(40);
        set_freq(0, 3, 0, 0);
        step(40);
        set_freq(7, 3, 0, 0);
        step(60);

        set_freq(1, 1, 1, 1);
        step(40);
        set_freq(255, 255, 0, 0);
        step(60);

        repeat (25) begin
            for (int v = 0; v < 4; v++)
                freq[v] = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 9));
            step(int'($urandom_range(3, 20)));
        end

        // Asynchronous reset mid-run: outputs must clear before any clk edge
        set_freq(5, 1, 1, 1);
        step(20);
        #2 reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("async_voice", int'(voice_o[d]), 0);
            check("async_mix",   int'(mix_o[d]),   0);
            check("async_pwm",   int'(pwm_o[d]),   0);
            check("async_tick",  int'(tick_o[d]),  0);
        end
        step(1);
        set_freq(5, 0, 0, 0);
        reset = 1'b1;
        step(80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
